// File: rtl/div_unit_pkg.sv
// Shared types and constants for the HI/LO multicycle arithmetic units.
// The control unit uses the latency constants to bound its wait states.
package div_unit_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    // Edges from the start-sampling edge until stop is high.
    localparam int DIV_LAT_NORMAL = DIV_WIDTH + 3;
    localparam int DIV_LAT_ZERO   = 2;
    localparam int MD_WAIT_MAX    = DIV_LAT_NORMAL;

    function automatic int div_latency(input int width, input logic by_zero);
        return by_zero ? DIV_LAT_ZERO : (width + 3);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    // One extra bit: for unsigned operands the shifted remainder can exceed WIDTH bits.
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {i_rem, i_dvd_msb};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_q_bit   = (w_shifted >= {1'b0, i_divisor});
    assign o_rem     = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Sequential signed integer divider (MIPS DIV semantics) with start/stop handshake.
// Optional DIV_UNSIGNED_EN adds the is_unsigned input for DIVU semantics.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             stop,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t r_state;
    div_state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;
    logic             r_stop;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_uns;
    logic             w_stop_next;
    logic             w_dz_next;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;

    // stop trails the DONE state by one cycle, so a start seen while stop is
    // high must still be refused even though the FSM is already back in IDLE.
    assign w_accept = (r_state == IDLE) && start && !r_stop;

`ifdef DIV_UNSIGNED_EN
    logic r_uns;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_uns <= 1'b0;
        end else if (w_accept) begin
            r_uns <= is_unsigned;
        end
    end

    assign w_uns = r_uns;
`else
    assign w_uns = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = CHECK;
            CHECK:   w_state_next = (r_b == '0) ? DONE : RUN;
            RUN:     if (r_cnt == LAST_CNT) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_stop_next = 1'b0;
        w_dz_next   = 1'b0;
        if (r_state == DONE) begin
            w_stop_next = 1'b1;
            w_dz_next   = r_dz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stop     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_stop     <= w_stop_next;
            r_div_zero <= w_dz_next;
        end
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_dvd_msb(r_dvd[WIDTH-1]),
        .i_divisor(r_div),
        .o_rem    (w_rem_next),
        .o_q_bit  (w_q_bit)
    );

    // r_dvd doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a  <= a_in;
                        r_b  <= b_in;
                        r_dz <= 1'b0;
                    end
                end
                CHECK: begin
                    r_dz     <= (r_b == '0);
                    r_sign_q <= !w_uns && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_sign_r <= !w_uns && r_a[WIDTH-1];
                    r_dvd    <= (!w_uns && r_a[WIDTH-1]) ? -r_a : r_a;
                    r_div    <= (!w_uns && r_b[WIDTH-1]) ? -r_b : r_b;
                    r_rem    <= '0;
                    r_cnt    <= '0;
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    r_lo <= r_sign_q ? -r_dvd : r_dvd;
                    r_hi <= r_sign_r ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end

    assign stop     = r_stop;
    assign div_zero = r_div_zero;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: fixed vectors, handshake corner sequences
// and randomized operands against a plain-arithmetic division model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        start;
    logic        stop;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;
`ifdef DIV_UNSIGNED_EN
    logic        is_unsigned;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] prev_lo = '0;
    logic [31:0] prev_hi = '0;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .start      (start),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned(is_unsigned),
`endif
        .stop       (stop),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .div_zero   (div_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        bit          dz;
        bit          disturb;
        bit          poke;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic truncates toward zero with the remainder
    // taking the dividend's sign, and cannot overflow on 0x80000000 / -1.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit uns,
                                    output logic [31:0] q, output logic [31:0] r);
        longint na;
        longint nb;
        longint lq;
        longint lr;
        if (uns) begin
            na = longint'(a);
            nb = longint'(b);
        end else begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end
        lq = na / nb;
        lr = na % nb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    task automatic watch_quiet(input int cycles, input string name);
        int n_stop = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (stop === 1'b1) n_stop++;
        end
        chk(name, 64'(n_stop), 64'd0);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit uns,
                           input logic [31:0] elo, input logic [31:0] ehi, input bit edz,
                           input bit disturb, input bit poke, input string tag);
        int    lat  = 0;
        bit    seen = 0;
        int    elat = edz ? 2 : 35;
        string nm   = $sformatf("%s%s", tag, uns ? "_u" : "");
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
`ifdef DIV_UNSIGNED_EN
        is_unsigned = uns;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (stop === 1'b1) begin
                seen = 1;
            end else if (disturb && (lat == 5 || lat == 20)) begin
                start = 1'b1;
                a_in  = $urandom;
                b_in  = 32'd0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            chk({nm, ".timeout"}, 64'(lat), 64'(elat));
        end else begin
            chk({nm, ".latency"}, 64'(lat), 64'(elat));
            chk({nm, ".lo"}, 64'(lo_out), 64'(elo));
            chk({nm, ".hi"}, 64'(hi_out), 64'(ehi));
            chk({nm, ".dz"}, 64'(div_zero), 64'(edz));
            if (poke) begin
                start = 1'b1;
                a_in  = 32'd9;
                b_in  = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            chk({nm, ".stop_pulse"}, 64'({stop, div_zero}), 64'd0);
            if (disturb) watch_quiet(40, {nm, ".single_stop"});
            if (poke) watch_quiet(40, {nm, ".start_on_stop_ignored"});
        end
        prev_lo = elo;
        prev_hi = ehi;
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rq;
        logic [31:0] rr;

        vecs[0] = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'd5,        32'd0,        32'hFFFFFFFD, 32'd1,        1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h12345678, 32'd1,        32'h12345678, 32'd0,        1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
`ifdef DIV_UNSIGNED_EN
        is_unsigned = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset.stop", 64'(stop), 64'd0);
        chk("reset.dz", 64'(div_zero), 64'd0);
        chk("reset.lo", 64'(lo_out), 64'd0);
        chk("reset.hi", 64'(hi_out), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, 1'b0, vecs[i].lo, vecs[i].hi, vecs[i].dz,
                    vecs[i].disturb, vecs[i].poke, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a division aborts it without a stop pulse.
        @(negedge clk);
        a_in  = 32'd100;
        b_in  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset.outputs", {30'd0, stop, div_zero, lo_out}, 64'd0);
        chk("midreset.hi", 64'(hi_out), 64'd0);
        reset = 1'b0;
        prev_lo = '0;
        prev_hi = '0;
        watch_quiet(40, "midreset.no_stop");
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, "after_reset");

`ifdef DIV_UNSIGNED_EN
        run_div(32'hFFFFFFFF, 32'd2, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, "divu");
        run_div(32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "divs");
`endif

        for (int i = 0; i < 24; i++) begin
            bit uns = 1'b0;
`ifdef DIV_UNSIGNED_EN
            uns = 1'($urandom_range(0, 1));
`endif
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if (rb == 32'd0) begin
                run_div(ra, rb, uns, prev_lo, prev_hi, 1'b1, 1'b0, 1'b0, $sformatf("rnd%0d", i));
            end else begin
                ref_div(ra, rb, uns, rq, rr);
                run_div(ra, rb, uns, rq, rr, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
